coo_encoder: RTL and testbench
==============================

Name: coo_encoder

Overview:
Converts a dense adjacency matrix into a stream of packed COO edge entries. It is the producer for the COO decoder path in the GCN datapath.
On a start pulse it reads the adjacency matrix row by row from a synchronous memory. It scans each row for set bits and emits one packed {src, dst} entry per edge over a valid/ready handshake. When the scan finishes it reports the total edge count.

Parameters:
NUM_NODES, 6, number of graph nodes; the adjacency matrix is NUM_NODES x NUM_NODES
COO_BW, 3, bit width of each COO field
ADDR_WIDTH, 3, adjacency memory row-address width
COO_ONE_INDEXED, 1, 1 = emitted indices are node+1 (1..NUM_NODES); 0 = emitted indices are 0-indexed
CNT_WIDTH, 6, edge counter width; must satisfy 2^CNT_WIDTH > NUM_NODES*NUM_NODES

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins an encode pass; ignored unless in IDLE
adj_rd_en  output  1  adjacency memory read enable
adj_addr  output  ADDR_WIDTH  adjacency row address (row = source node)
adj_rdata  input  NUM_NODES  row word; bit c set = edge src=row to dst=c; data valid the cycle after adj_rd_en
coo_out  output  2*COO_BW  packed {src[2*COO_BW-1:COO_BW], dst[COO_BW-1:0]}
coo_valid  output  1  coo_out holds a valid edge
coo_ready  input  1  consumer accepts coo_out when coo_valid and coo_ready are both high
edge_count  output  CNT_WIDTH  number of edges accepted in the current/last pass
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the pass is complete

Behaviour:
- Reset: all outputs go to 0; state goes to IDLE; row and column counters and row_reg are cleared. Reset asserted mid-pass aborts the pass, and any pending edge is dropped.
- States: IDLE, READ, LOAD, SCAN, FLUSH, DONE.
- IDLE: on start, clear edge_count and row=0, then go to READ.
- READ: adj_rd_en=1 and adj_addr=row for exactly one cycle, then go to LOAD.
- LOAD: row_reg <= adj_rdata, col=0, then go to SCAN.
- SCAN: examines row_reg[col] once per cycle. The output register may load when it is empty or is being accepted in the same cycle.
  - If the bit is set and the output register can load: coo_out <= {row+OFS, col+OFS}, where OFS = COO_ONE_INDEXED. Set coo_valid <= 1 and advance col.
  - If the bit is set and the output register cannot load: stall. col holds.
  - If the bit is clear: advance col. No output is produced.
- After col = NUM_NODES-1 is consumed:
  - If row < NUM_NODES-1: row++ and go to READ.
  - Otherwise go to FLUSH.
- FLUSH: wait until coo_valid is 0, or until the pending edge is accepted this cycle. Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. busy is 0 from IDLE onward.
- Handshake rules:
  - coo_out and coo_valid are registered.
  - While coo_valid=1 and coo_ready=0, coo_out must hold stable.
  - coo_valid drops the cycle after acceptance unless a new edge loads in that same cycle (back-to-back edges allowed).
- edge_count increments on each accepted handshake. It holds its value after DONE until the next start.
- Emission order: row-major, ascending src, then ascending dst within the row.
- Throughput: at most one edge per cycle within a row; each row costs 2 cycles of READ/LOAD overhead.
- Empty matrix: no coo_valid is ever raised; done fires with edge_count=0.
- Self-loops (bit r in row r) are emitted like any other edge.
- start asserted while busy is ignored.
- Widths: field = node index + OFS, truncated to COO_BW. The parameters must guarantee NUM_NODES-1+OFS < 2^COO_BW; flag a violation at elaboration.

Test Plan:
- Reset during SCAN with coo_valid=1 -> coo_valid, busy, done and edge_count go to 0 immediately. A new start then runs a clean pass.
- Rows 0..5 = 000110, 0, 0, 100000, 0, 0 with coo_ready=1 -> coo_out = 001010, 001011, 100110; then done pulse, edge_count=3.
- Same matrix, coo_ready held low for 5 cycles on the first edge -> coo_out=001010 stays stable throughout; the sequence is unchanged and edge_count=3.
- All-zero matrix -> coo_valid never asserts; done pulses after 6 READ/LOAD pairs and 6x6 scan cycles; edge_count=0.
- Full matrix (all rows 111111), coo_ready=1 -> 36 edges, back-to-back within each row, from {1,1} through {6,6}; edge_count=36.
- COO_ONE_INDEXED=0, row 2 = 000001 -> single coo_out = {3'd2, 3'd0} = 010000. Also pulse start during the pass -> the pulse is ignored and no second pass runs.

Source files
------------

// File: rtl/coo_encoder.sv
`default_nettype none
// ============================================================================
// Module      : coo_encoder
// Description : Scans a dense adjacency matrix row by row and streams one
//               packed {src, dst} COO entry per set bit over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module coo_encoder #(
    parameter int NUM_NODES       = 6,
    parameter int COO_BW          = 3,
    parameter int ADDR_WIDTH      = 3,
    parameter int COO_ONE_INDEXED = 1,
    parameter int CNT_WIDTH       = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    adj_rd_en,
    output logic [ADDR_WIDTH-1:0]   adj_addr,
    input  logic [NUM_NODES-1:0]    adj_rdata,
    output logic [2*COO_BW-1:0]     coo_out,
    output logic                    coo_valid,
    input  logic                    coo_ready,
    output logic [CNT_WIDTH-1:0]    edge_count,
    output logic                    busy,
    output logic                    done
);

    localparam int c_col_w = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

    generate
        if (NUM_NODES - 1 + COO_ONE_INDEXED >= (1 << COO_BW)) begin : g_bad_coo_bw
            $error("coo_encoder: COO_BW too narrow for NUM_NODES and index offset");
        end
        if ((1 << ADDR_WIDTH) < NUM_NODES) begin : g_bad_addr_width
            $error("coo_encoder: ADDR_WIDTH too narrow for NUM_NODES rows");
        end
        if ((1 << CNT_WIDTH) <= NUM_NODES * NUM_NODES) begin : g_bad_cnt_width
            $error("coo_encoder: CNT_WIDTH cannot hold NUM_NODES*NUM_NODES edges");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_SCAN  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_row;
    logic [c_col_w-1:0]     r_col;
    logic [NUM_NODES-1:0]   r_row_reg;
    logic [2*COO_BW-1:0]    r_coo_out;
    logic                   r_coo_valid;
    logic [CNT_WIDTH-1:0]   r_edge_count;

    logic                   w_accept;
    logic                   w_can_load;
    logic                   w_bit;
    logic                   w_emit;
    logic                   w_advance;
    logic                   w_col_last;
    logic                   w_row_last;
    logic [COO_BW-1:0]      w_src;
    logic [COO_BW-1:0]      w_dst;

    // The output register may refill in the same cycle its current entry is taken.
    assign w_accept   = r_coo_valid & coo_ready;
    assign w_can_load = ~r_coo_valid | coo_ready;
    assign w_bit      = r_row_reg[r_col];
    assign w_emit     = (r_state == S_SCAN) & w_bit & w_can_load;
    assign w_advance  = (r_state == S_SCAN) & (~w_bit | w_can_load);
    assign w_col_last = (r_col == c_col_w'(NUM_NODES - 1));
    assign w_row_last = (r_row == ADDR_WIDTH'(NUM_NODES - 1));
    assign w_src      = COO_BW'(r_row) + COO_BW'(COO_ONE_INDEXED);
    assign w_dst      = COO_BW'(r_col) + COO_BW'(COO_ONE_INDEXED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        adj_rd_en   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                adj_rd_en   = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (w_advance && w_col_last) begin
                    w_state_nxt = w_row_last ? S_FLUSH : S_READ;
                end
            end
            S_FLUSH: begin
                if (!r_coo_valid || coo_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_row_reg    <= '0;
            r_coo_out    <= '0;
            r_coo_valid  <= 1'b0;
            r_edge_count <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_edge_count <= '0;
                r_row        <= '0;
            end else if (w_accept) begin
                r_edge_count <= r_edge_count + 1'b1;
            end

            if (r_state == S_LOAD) begin
                r_row_reg <= adj_rdata;
                r_col     <= '0;
            end

            if (w_advance) begin
                if (w_col_last) begin
                    r_col <= '0;
                    if (!w_row_last) begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_emit) begin
                r_coo_out   <= {w_src, w_dst};
                r_coo_valid <= 1'b1;
            end else if (w_accept) begin
                r_coo_valid <= 1'b0;
            end
        end
    end

    assign adj_addr   = r_row;
    assign coo_out    = r_coo_out;
    assign coo_valid  = r_coo_valid;
    assign edge_count = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_coo_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_coo_encoder
// Description : Directed and randomized self-checking bench for coo_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coo_encoder;

    localparam int N  = 6;
    localparam int BW = 3;
    localparam int AW = 3;
    localparam int CW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start0, start1;
    logic          coo_ready;
    logic          sel;
    logic [N-1:0]  adj_rdata;
    logic [N-1:0]  mem [N];

    logic          rd0, rd1, v0, v1, busy0, busy1, done0, done1;
    logic [AW-1:0] addr0, addr1;
    logic [2*BW-1:0] out0, out1;
    logic [CW-1:0] ec0, ec1;

    coo_encoder #(.NUM_NODES(N), .COO_BW(BW), .ADDR_WIDTH(AW),
                  .COO_ONE_INDEXED(1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .adj_rd_en(rd0), .adj_addr(addr0), .adj_rdata(adj_rdata),
        .coo_out(out0), .coo_valid(v0), .coo_ready(coo_ready),
        .edge_count(ec0), .busy(busy0), .done(done0)
    );

    coo_encoder #(.NUM_NODES(N), .COO_BW(BW), .ADDR_WIDTH(AW),
                  .COO_ONE_INDEXED(0), .CNT_WIDTH(CW)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .adj_rd_en(rd1), .adj_addr(addr1), .adj_rdata(adj_rdata),
        .coo_out(out1), .coo_valid(v1), .coo_ready(coo_ready),
        .edge_count(ec1), .busy(busy1), .done(done1)
    );

    // Synchronous adjacency memory shared by whichever instance is selected.
    always @(posedge clk) begin
        if (sel ? rd1 : rd0) adj_rdata <= mem[sel ? addr1 : addr0];
    end

    logic            o_rd, o_valid, o_busy, o_done;
    logic [2*BW-1:0] o_out;
    logic [CW-1:0]   o_ec;
    assign o_rd    = sel ? rd1   : rd0;
    assign o_valid = sel ? v1    : v0;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_done  = sel ? done1 : done0;
    assign o_out   = sel ? out1  : out0;
    assign o_ec    = sel ? ec1   : ec0;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    // mode 0: ready always high; 1: random ready; 2: first edge held off 5 cycles
    task automatic run_pass(input int mode, input bit inject_start, input bit check_lat);
        logic [2*BW-1:0] expq[$];
        logic [2*BW-1:0] exp_e;
        logic [2*BW-1:0] prev_out;
        int ofs, n, n_done, stall, reads, got, total;
        bit seen_done, prev_hold, stray;

        ofs = sel ? 0 : 1;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (mem[r][c]) begin
                    exp_e = {3'(r + ofs), 3'(c + ofs)};
                    expq.push_back(exp_e);
                end
        total = expq.size();

        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        n = 0; n_done = -1; stall = 0; reads = 0; got = 0;
        seen_done = 0; prev_hold = 0; prev_out = '0;

        while (!seen_done && n < 400) begin
            case (mode)
                1:       coo_ready = 1'($urandom_range(0, 1));
                2: begin
                    coo_ready = !(o_valid && got == 0 && stall < 5);
                    if (!coo_ready) stall++;
                end
                default: coo_ready = 1'b1;
            endcase
            if (inject_start) begin
                if (n == 10)      set_start(1'b1);
                else if (n == 11) set_start(1'b0);
            end
            if (prev_hold) begin
                check("hold_valid", 32'(o_valid), 32'd1);
                check("hold_data", 32'(o_out), 32'(prev_out));
            end
            if (o_rd) reads++;
            check("busy_in_pass", 32'(o_busy), 32'd1);
            if (o_done) begin
                seen_done = 1;
                n_done    = n;
                check("valid_at_done", 32'(o_valid), 32'd0);
            end else if (o_valid && coo_ready) begin
                if (expq.size() == 0) check("edge_unexpected", 32'(expq.size()), 32'd1);
                else                  check("edge_data", 32'(o_out), 32'(expq.pop_front()));
                got++;
            end
            prev_hold = o_valid && !coo_ready;
            prev_out  = o_out;
            @(negedge clk);
            n++;
        end
        set_start(1'b0);
        coo_ready = 1'b1;

        check("done_seen", 32'(seen_done), 32'd1);
        check("edge_count", 32'(o_ec), 32'(total));
        check("edges_accepted", 32'(got), 32'(total));
        check("row_reads", 32'(reads), 32'(N));
        if (check_lat) check("done_latency", 32'(n_done), 32'(8 * N + 1));
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_done", 32'(o_done), 32'd0);

        if (inject_start) begin
            stray = 0;
            for (int k = 0; k < 20; k++) begin
                if (o_busy || o_valid) stray = 1;
                @(negedge clk);
            end
            check("no_second_pass", 32'(stray), 32'd0);
            check("count_held", 32'(o_ec), 32'(total));
        end
    endtask

    task automatic fill(input logic [N-1:0] r0, r1, r2, r3, r4, r5);
        mem[0] = r0; mem[1] = r1; mem[2] = r2;
        mem[3] = r3; mem[4] = r4; mem[5] = r5;
    endtask

    initial begin
        int waited;
        reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        coo_ready = 1'b0; sel = 1'b0;
        fill('0, '0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_count", 32'(o_ec), 32'd0);
        check("rst_rd_en", 32'(o_rd), 32'd0);
        check("rst_out", 32'(o_out), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // sparse matrix with unconditional ready
        fill(6'b000110, '0, '0, 6'b100000, '0, '0);
        run_pass(0, 0, 1);
        // same matrix, first edge back-pressured
        run_pass(2, 0, 0);
        // empty matrix
        fill('0, '0, '0, '0, '0, '0);
        run_pass(0, 0, 1);
        // full matrix, back-to-back edges
        fill('1, '1, '1, '1, '1, '1);
        run_pass(0, 0, 1);

        // zero-indexed instance, stray start during the pass
        sel = 1'b1;
        fill('0, '0, 6'b000001, '0, '0, '0);
        run_pass(0, 1, 1);

        // asynchronous reset in the middle of a pass with an edge pending
        sel = 1'b0;
        fill('1, '1, '1, '1, '1, '1);
        coo_ready = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        waited = 0;
        while (!o_valid && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("pre_reset_valid", 32'(o_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_done", 32'(o_done), 32'd0);
        check("midrst_count", 32'(o_ec), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        coo_ready = 1'b1;
        run_pass(0, 0, 1);

        // randomized matrices and random back-pressure on both instances
        for (int t = 0; t < 8; t++) begin
            sel = 1'(t % 2);
            for (int r = 0; r < N; r++) mem[r] = N'($urandom);
            run_pass(1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
